// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - AXI encodings and counter sizing helper shared by the limiter
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } axi_burst_e;

    // Bits needed to hold 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/txn_counter.sv
// rtl/txn_counter.sv - saturating up/down transaction counter with full and underflow flags
module txn_counter
    import axi_pkg::*;
#(
    parameter int MAX   = 8,
    parameter int WIDTH = cnt_width(MAX)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count,
    output logic             o_full,
    output logic             o_underflow
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);

    logic [WIDTH-1:0] r_count;
    logic             w_empty;

    assign w_empty     = (r_count == '0);
    assign o_full      = (r_count == MAX_VAL);
    assign o_count     = r_count;
    // A completion with nothing in flight is flagged even if a new request lands in the same cycle.
    assign o_underflow = i_dec & w_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_inc & ~i_dec & ~o_full) begin
            r_count <= r_count + 1'b1;
        end else if (i_dec & ~i_inc & ~w_empty) begin
            r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/axi_outstanding_limiter.sv
// rtl/axi_outstanding_limiter.sv - AXI4 pass-through capping in-flight read/write bursts
module axi_outstanding_limiter
    import axi_pkg::*;
#(
    parameter int BYTES_PER_WORD     = 16,
    parameter int ADDRESS_WIDTH      = 32,
    parameter int ID_WIDTH           = 6,
    parameter int MAX_RD_OUTSTANDING = 8,
    parameter int MAX_WR_OUTSTANDING = 8
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [ADDRESS_WIDTH-1:0]      S_AXI_araddr,
    input  logic [7:0]                    S_AXI_arlen,
    input  logic [2:0]                    S_AXI_arprot,
    input  logic [2:0]                    S_AXI_arsize,
    input  logic [1:0]                    S_AXI_arburst,
    input  logic                          S_AXI_arlock,
    input  logic [3:0]                    S_AXI_arcache,
    input  logic [3:0]                    S_AXI_arqos,
    input  logic [3:0]                    S_AXI_arregion,
    input  logic                          S_AXI_aruser,
    input  logic [ID_WIDTH-1:0]           S_AXI_arid,
    input  logic                          S_AXI_arvalid,
    output logic                          S_AXI_arready,
    input  logic [ADDRESS_WIDTH-1:0]      S_AXI_awaddr,
    input  logic [7:0]                    S_AXI_awlen,
    input  logic [2:0]                    S_AXI_awprot,
    input  logic [2:0]                    S_AXI_awsize,
    input  logic [1:0]                    S_AXI_awburst,
    input  logic                          S_AXI_awlock,
    input  logic [3:0]                    S_AXI_awcache,
    input  logic [3:0]                    S_AXI_awqos,
    input  logic [3:0]                    S_AXI_awregion,
    input  logic                          S_AXI_awuser,
    input  logic [ID_WIDTH-1:0]           S_AXI_awid,
    input  logic                          S_AXI_awvalid,
    output logic                          S_AXI_awready,
    input  logic [BYTES_PER_WORD*8-1:0]   S_AXI_wdata,
    input  logic [BYTES_PER_WORD-1:0]     S_AXI_wstrb,
    input  logic                          S_AXI_wlast,
    input  logic                          S_AXI_wvalid,
    output logic                          S_AXI_wready,
    output logic [BYTES_PER_WORD*8-1:0]   S_AXI_rdata,
    output logic                          S_AXI_rlast,
    output logic [ID_WIDTH-1:0]           S_AXI_rid,
    output logic [1:0]                    S_AXI_rresp,
    output logic                          S_AXI_ruser,
    output logic                          S_AXI_rvalid,
    input  logic                          S_AXI_rready,
    output logic [ID_WIDTH-1:0]           S_AXI_bid,
    output logic [1:0]                    S_AXI_bresp,
    output logic                          S_AXI_buser,
    output logic                          S_AXI_bvalid,
    input  logic                          S_AXI_bready,
    output logic [ADDRESS_WIDTH-1:0]      M_AXI_araddr,
    output logic [7:0]                    M_AXI_arlen,
    output logic [2:0]                    M_AXI_arprot,
    output logic [2:0]                    M_AXI_arsize,
    output logic [1:0]                    M_AXI_arburst,
    output logic                          M_AXI_arlock,
    output logic [3:0]                    M_AXI_arcache,
    output logic [3:0]                    M_AXI_arqos,
    output logic [3:0]                    M_AXI_arregion,
    output logic                          M_AXI_aruser,
    output logic [ID_WIDTH-1:0]           M_AXI_arid,
    output logic                          M_AXI_arvalid,
    input  logic                          M_AXI_arready,
    output logic [ADDRESS_WIDTH-1:0]      M_AXI_awaddr,
    output logic [7:0]                    M_AXI_awlen,
    output logic [2:0]                    M_AXI_awprot,
    output logic [2:0]                    M_AXI_awsize,
    output logic [1:0]                    M_AXI_awburst,
    output logic                          M_AXI_awlock,
    output logic [3:0]                    M_AXI_awcache,
    output logic [3:0]                    M_AXI_awqos,
    output logic [3:0]                    M_AXI_awregion,
    output logic                          M_AXI_awuser,
    output logic [ID_WIDTH-1:0]           M_AXI_awid,
    output logic                          M_AXI_awvalid,
    input  logic                          M_AXI_awready,
    output logic [BYTES_PER_WORD*8-1:0]   M_AXI_wdata,
    output logic [BYTES_PER_WORD-1:0]     M_AXI_wstrb,
    output logic                          M_AXI_wlast,
    output logic                          M_AXI_wvalid,
    input  logic                          M_AXI_wready,
    input  logic [BYTES_PER_WORD*8-1:0]   M_AXI_rdata,
    input  logic                          M_AXI_rlast,
    input  logic [ID_WIDTH-1:0]           M_AXI_rid,
    input  logic [1:0]                    M_AXI_rresp,
    input  logic                          M_AXI_ruser,
    input  logic                          M_AXI_rvalid,
    output logic                          M_AXI_rready,
    input  logic [ID_WIDTH-1:0]           M_AXI_bid,
    input  logic [1:0]                    M_AXI_bresp,
    input  logic                          M_AXI_buser,
    input  logic                          M_AXI_bvalid,
    output logic                          M_AXI_bready,
    output logic [7:0]                    rd_outstanding,
    output logic [7:0]                    wr_outstanding,
    output logic                          protocol_err
);

    localparam int RD_W = cnt_width(MAX_RD_OUTSTANDING);
    localparam int WR_W = cnt_width(MAX_WR_OUTSTANDING);

    logic [RD_W-1:0] w_rd_cnt;
    logic [WR_W-1:0] w_wr_cnt;
    logic [WR_W-1:0] w_wpend;
    logic            w_rd_full, w_wr_full, w_wpend_full;
    logic            w_rd_uflow, w_wr_uflow, w_wpend_uflow;
    logic            w_ar_block, w_aw_block, w_w_open;
    logic            w_ar_hs, w_r_done, w_aw_hs, w_b_hs, w_w_last_hs;
    logic            r_protocol_err;

    assign M_AXI_araddr   = S_AXI_araddr;
    assign M_AXI_arlen    = S_AXI_arlen;
    assign M_AXI_arprot   = S_AXI_arprot;
    assign M_AXI_arsize   = S_AXI_arsize;
    assign M_AXI_arburst  = S_AXI_arburst;
    assign M_AXI_arlock   = S_AXI_arlock;
    assign M_AXI_arcache  = S_AXI_arcache;
    assign M_AXI_arqos    = S_AXI_arqos;
    assign M_AXI_arregion = S_AXI_arregion;
    assign M_AXI_aruser   = S_AXI_aruser;
    assign M_AXI_arid     = S_AXI_arid;

    assign M_AXI_awaddr   = S_AXI_awaddr;
    assign M_AXI_awlen    = S_AXI_awlen;
    assign M_AXI_awprot   = S_AXI_awprot;
    assign M_AXI_awsize   = S_AXI_awsize;
    assign M_AXI_awburst  = S_AXI_awburst;
    assign M_AXI_awlock   = S_AXI_awlock;
    assign M_AXI_awcache  = S_AXI_awcache;
    assign M_AXI_awqos    = S_AXI_awqos;
    assign M_AXI_awregion = S_AXI_awregion;
    assign M_AXI_awuser   = S_AXI_awuser;
    assign M_AXI_awid     = S_AXI_awid;

    assign M_AXI_wdata    = S_AXI_wdata;
    assign M_AXI_wstrb    = S_AXI_wstrb;
    assign M_AXI_wlast    = S_AXI_wlast;

    assign S_AXI_rdata    = M_AXI_rdata;
    assign S_AXI_rlast    = M_AXI_rlast;
    assign S_AXI_rid      = M_AXI_rid;
    assign S_AXI_rresp    = M_AXI_rresp;
    assign S_AXI_ruser    = M_AXI_ruser;
    assign S_AXI_rvalid   = M_AXI_rvalid;
    assign M_AXI_rready   = S_AXI_rready;

    assign S_AXI_bid      = M_AXI_bid;
    assign S_AXI_bresp    = M_AXI_bresp;
    assign S_AXI_buser    = M_AXI_buser;
    assign S_AXI_bvalid   = M_AXI_bvalid;
    assign M_AXI_bready   = S_AXI_bready;

    // Gating looks only at registered counts, so a completion frees a slot one cycle later.
    assign w_ar_block    = w_rd_full;
    // wpend never exceeds wr_cnt, so the wpend term is a backstop rather than a second limit.
    assign w_aw_block    = w_wr_full | w_wpend_full;
    assign w_w_open      = (w_wpend != '0);

    assign M_AXI_arvalid = S_AXI_arvalid & ~w_ar_block;
    assign S_AXI_arready = M_AXI_arready & ~w_ar_block;
    assign M_AXI_awvalid = S_AXI_awvalid & ~w_aw_block;
    assign S_AXI_awready = M_AXI_awready & ~w_aw_block;
    assign M_AXI_wvalid  = S_AXI_wvalid & w_w_open;
    assign S_AXI_wready  = M_AXI_wready & w_w_open;

    assign w_ar_hs       = M_AXI_arvalid & M_AXI_arready;
    assign w_r_done      = M_AXI_rvalid & S_AXI_rready & M_AXI_rlast;
    assign w_aw_hs       = M_AXI_awvalid & M_AXI_awready;
    assign w_b_hs        = M_AXI_bvalid & S_AXI_bready;
    assign w_w_last_hs   = M_AXI_wvalid & M_AXI_wready & S_AXI_wlast;

    txn_counter #(.MAX(MAX_RD_OUTSTANDING), .WIDTH(RD_W)) u_rd_cnt (
        .i_clk(CLK), .i_rst_n(RST_N), .i_inc(w_ar_hs), .i_dec(w_r_done),
        .o_count(w_rd_cnt), .o_full(w_rd_full), .o_underflow(w_rd_uflow)
    );

    txn_counter #(.MAX(MAX_WR_OUTSTANDING), .WIDTH(WR_W)) u_wr_cnt (
        .i_clk(CLK), .i_rst_n(RST_N), .i_inc(w_aw_hs), .i_dec(w_b_hs),
        .o_count(w_wr_cnt), .o_full(w_wr_full), .o_underflow(w_wr_uflow)
    );

    txn_counter #(.MAX(MAX_WR_OUTSTANDING), .WIDTH(WR_W)) u_wpend (
        .i_clk(CLK), .i_rst_n(RST_N), .i_inc(w_aw_hs), .i_dec(w_w_last_hs),
        .o_count(w_wpend), .o_full(w_wpend_full), .o_underflow(w_wpend_uflow)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_protocol_err <= 1'b0;
        end else if (w_rd_uflow | w_wr_uflow | w_wpend_uflow) begin
            r_protocol_err <= 1'b1;
        end
    end

    assign protocol_err   = r_protocol_err;
    assign rd_outstanding = 8'(w_rd_cnt);
    assign wr_outstanding = 8'(w_wr_cnt);

endmodule

// File: tb/tb_axi_outstanding_limiter.sv
// tb/tb_axi_outstanding_limiter.sv - directed self-checking bench for axi_outstanding_limiter
module tb_axi_outstanding_limiter;

    localparam int BPW = 16;
    localparam int AW  = 32;
    localparam int IDW = 6;

    logic CLK, RST_N;
    logic [AW-1:0] S_AXI_araddr, S_AXI_awaddr, M_AXI_araddr, M_AXI_awaddr;
    logic [7:0] S_AXI_arlen, S_AXI_awlen, M_AXI_arlen, M_AXI_awlen;
    logic [2:0] S_AXI_arprot, S_AXI_arsize, S_AXI_awprot, S_AXI_awsize;
    logic [2:0] M_AXI_arprot, M_AXI_arsize, M_AXI_awprot, M_AXI_awsize;
    logic [1:0] S_AXI_arburst, S_AXI_awburst, M_AXI_arburst, M_AXI_awburst;
    logic S_AXI_arlock, S_AXI_awlock, M_AXI_arlock, M_AXI_awlock;
    logic [3:0] S_AXI_arcache, S_AXI_arqos, S_AXI_arregion, S_AXI_awcache, S_AXI_awqos, S_AXI_awregion;
    logic [3:0] M_AXI_arcache, M_AXI_arqos, M_AXI_arregion, M_AXI_awcache, M_AXI_awqos, M_AXI_awregion;
    logic S_AXI_aruser, S_AXI_awuser, M_AXI_aruser, M_AXI_awuser;
    logic [IDW-1:0] S_AXI_arid, S_AXI_awid, M_AXI_arid, M_AXI_awid;
    logic S_AXI_arvalid, S_AXI_arready, S_AXI_awvalid, S_AXI_awready;
    logic M_AXI_arvalid, M_AXI_arready, M_AXI_awvalid, M_AXI_awready;
    logic [BPW*8-1:0] S_AXI_wdata, M_AXI_wdata, S_AXI_rdata, M_AXI_rdata;
    logic [BPW-1:0] S_AXI_wstrb, M_AXI_wstrb;
    logic S_AXI_wlast, S_AXI_wvalid, S_AXI_wready, M_AXI_wlast, M_AXI_wvalid, M_AXI_wready;
    logic S_AXI_rlast, S_AXI_ruser, S_AXI_rvalid, S_AXI_rready;
    logic M_AXI_rlast, M_AXI_ruser, M_AXI_rvalid, M_AXI_rready;
    logic [IDW-1:0] S_AXI_rid, M_AXI_rid, S_AXI_bid, M_AXI_bid;
    logic [1:0] S_AXI_rresp, M_AXI_rresp, S_AXI_bresp, M_AXI_bresp;
    logic S_AXI_buser, S_AXI_bvalid, S_AXI_bready, M_AXI_buser, M_AXI_bvalid, M_AXI_bready;
    logic [7:0] rd_outstanding, wr_outstanding;
    logic protocol_err;

    int n_cmp = 0;
    int n_bad = 0;

    axi_outstanding_limiter #(
        .BYTES_PER_WORD(BPW), .ADDRESS_WIDTH(AW), .ID_WIDTH(IDW),
        .MAX_RD_OUTSTANDING(3), .MAX_WR_OUTSTANDING(1)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .S_AXI_araddr(S_AXI_araddr), .S_AXI_arlen(S_AXI_arlen), .S_AXI_arprot(S_AXI_arprot),
        .S_AXI_arsize(S_AXI_arsize), .S_AXI_arburst(S_AXI_arburst), .S_AXI_arlock(S_AXI_arlock),
        .S_AXI_arcache(S_AXI_arcache), .S_AXI_arqos(S_AXI_arqos), .S_AXI_arregion(S_AXI_arregion),
        .S_AXI_aruser(S_AXI_aruser), .S_AXI_arid(S_AXI_arid), .S_AXI_arvalid(S_AXI_arvalid),
        .S_AXI_arready(S_AXI_arready),
        .S_AXI_awaddr(S_AXI_awaddr), .S_AXI_awlen(S_AXI_awlen), .S_AXI_awprot(S_AXI_awprot),
        .S_AXI_awsize(S_AXI_awsize), .S_AXI_awburst(S_AXI_awburst), .S_AXI_awlock(S_AXI_awlock),
        .S_AXI_awcache(S_AXI_awcache), .S_AXI_awqos(S_AXI_awqos), .S_AXI_awregion(S_AXI_awregion),
        .S_AXI_awuser(S_AXI_awuser), .S_AXI_awid(S_AXI_awid), .S_AXI_awvalid(S_AXI_awvalid),
        .S_AXI_awready(S_AXI_awready),
        .S_AXI_wdata(S_AXI_wdata), .S_AXI_wstrb(S_AXI_wstrb), .S_AXI_wlast(S_AXI_wlast),
        .S_AXI_wvalid(S_AXI_wvalid), .S_AXI_wready(S_AXI_wready),
        .S_AXI_rdata(S_AXI_rdata), .S_AXI_rlast(S_AXI_rlast), .S_AXI_rid(S_AXI_rid),
        .S_AXI_rresp(S_AXI_rresp), .S_AXI_ruser(S_AXI_ruser), .S_AXI_rvalid(S_AXI_rvalid),
        .S_AXI_rready(S_AXI_rready),
        .S_AXI_bid(S_AXI_bid), .S_AXI_bresp(S_AXI_bresp), .S_AXI_buser(S_AXI_buser),
        .S_AXI_bvalid(S_AXI_bvalid), .S_AXI_bready(S_AXI_bready),
        .M_AXI_araddr(M_AXI_araddr), .M_AXI_arlen(M_AXI_arlen), .M_AXI_arprot(M_AXI_arprot),
        .M_AXI_arsize(M_AXI_arsize), .M_AXI_arburst(M_AXI_arburst), .M_AXI_arlock(M_AXI_arlock),
        .M_AXI_arcache(M_AXI_arcache), .M_AXI_arqos(M_AXI_arqos), .M_AXI_arregion(M_AXI_arregion),
        .M_AXI_aruser(M_AXI_aruser), .M_AXI_arid(M_AXI_arid), .M_AXI_arvalid(M_AXI_arvalid),
        .M_AXI_arready(M_AXI_arready),
        .M_AXI_awaddr(M_AXI_awaddr), .M_AXI_awlen(M_AXI_awlen), .M_AXI_awprot(M_AXI_awprot),
        .M_AXI_awsize(M_AXI_awsize), .M_AXI_awburst(M_AXI_awburst), .M_AXI_awlock(M_AXI_awlock),
        .M_AXI_awcache(M_AXI_awcache), .M_AXI_awqos(M_AXI_awqos), .M_AXI_awregion(M_AXI_awregion),
        .M_AXI_awuser(M_AXI_awuser), .M_AXI_awid(M_AXI_awid), .M_AXI_awvalid(M_AXI_awvalid),
        .M_AXI_awready(M_AXI_awready),
        .M_AXI_wdata(M_AXI_wdata), .M_AXI_wstrb(M_AXI_wstrb), .M_AXI_wlast(M_AXI_wlast),
        .M_AXI_wvalid(M_AXI_wvalid), .M_AXI_wready(M_AXI_wready),
        .M_AXI_rdata(M_AXI_rdata), .M_AXI_rlast(M_AXI_rlast), .M_AXI_rid(M_AXI_rid),
        .M_AXI_rresp(M_AXI_rresp), .M_AXI_ruser(M_AXI_ruser), .M_AXI_rvalid(M_AXI_rvalid),
        .M_AXI_rready(M_AXI_rready),
        .M_AXI_bid(M_AXI_bid), .M_AXI_bresp(M_AXI_bresp), .M_AXI_buser(M_AXI_buser),
        .M_AXI_bvalid(M_AXI_bvalid), .M_AXI_bready(M_AXI_bready),
        .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
        .protocol_err(protocol_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Step to 1 ns after the next rising edge; inputs change and outputs are sampled there.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        S_AXI_araddr = '0; S_AXI_arlen = '0; S_AXI_arprot = '0; S_AXI_arsize = '0;
        S_AXI_arburst = '0; S_AXI_arlock = 0; S_AXI_arcache = '0; S_AXI_arqos = '0;
        S_AXI_arregion = '0; S_AXI_aruser = 0; S_AXI_arid = '0; S_AXI_arvalid = 0;
        S_AXI_awaddr = '0; S_AXI_awlen = '0; S_AXI_awprot = '0; S_AXI_awsize = '0;
        S_AXI_awburst = '0; S_AXI_awlock = 0; S_AXI_awcache = '0; S_AXI_awqos = '0;
        S_AXI_awregion = '0; S_AXI_awuser = 0; S_AXI_awid = '0; S_AXI_awvalid = 0;
        S_AXI_wdata = '0; S_AXI_wstrb = '0; S_AXI_wlast = 0; S_AXI_wvalid = 0;
        S_AXI_rready = 0; S_AXI_bready = 0;
        M_AXI_arready = 0; M_AXI_awready = 0; M_AXI_wready = 0;
        M_AXI_rdata = '0; M_AXI_rlast = 0; M_AXI_rid = '0; M_AXI_rresp = '0;
        M_AXI_ruser = 0; M_AXI_rvalid = 0;
        M_AXI_bid = '0; M_AXI_bresp = '0; M_AXI_buser = 0; M_AXI_bvalid = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        RST_N = 1'b0;
        S_AXI_wvalid = 1; M_AXI_wready = 1;
        #12;
        n_cmp++; if (rd_outstanding !== 8'd0) begin n_bad++; $display("FAIL reset_rd: got %0d want 0", rd_outstanding); end
        n_cmp++; if (wr_outstanding !== 8'd0) begin n_bad++; $display("FAIL reset_wr: got %0d want 0", wr_outstanding); end
        n_cmp++; if (protocol_err !== 1'b0) begin n_bad++; $display("FAIL reset_perr: got %0b want 0", protocol_err); end
        n_cmp++; if (M_AXI_wvalid !== 1'b0) begin n_bad++; $display("FAIL reset_wvalid: got %0b want 0", M_AXI_wvalid); end
        clear_inputs();
        tick();
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_passthrough();
        S_AXI_araddr = 32'hDEAD_BEEF; S_AXI_arlen = 8'h0F; S_AXI_arid = 6'h2A; S_AXI_arcache = 4'hA;
        S_AXI_awaddr = 32'h1234_5678; S_AXI_awburst = 2'b01; S_AXI_awqos = 4'h9;
        M_AXI_rdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        M_AXI_rid = 6'h15; M_AXI_rresp = 2'b10; M_AXI_bresp = 2'b11; S_AXI_rready = 1;
        #1;
        n_cmp++; if (M_AXI_araddr !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL pt_araddr: got %h want deadbeef", M_AXI_araddr); end
        n_cmp++; if (M_AXI_arlen !== 8'h0F) begin n_bad++; $display("FAIL pt_arlen: got %h want 0f", M_AXI_arlen); end
        n_cmp++; if (M_AXI_arid !== 6'h2A) begin n_bad++; $display("FAIL pt_arid: got %h want 2a", M_AXI_arid); end
        n_cmp++; if (M_AXI_arcache !== 4'hA) begin n_bad++; $display("FAIL pt_arcache: got %h want a", M_AXI_arcache); end
        n_cmp++; if (M_AXI_awaddr !== 32'h1234_5678) begin n_bad++; $display("FAIL pt_awaddr: got %h want 12345678", M_AXI_awaddr); end
        n_cmp++; if (M_AXI_awqos !== 4'h9) begin n_bad++; $display("FAIL pt_awqos: got %h want 9", M_AXI_awqos); end
        n_cmp++; if (S_AXI_rdata !== 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210) begin n_bad++; $display("FAIL pt_rdata: got %h", S_AXI_rdata); end
        n_cmp++; if (S_AXI_rid !== 6'h15) begin n_bad++; $display("FAIL pt_rid: got %h want 15", S_AXI_rid); end
        n_cmp++; if (S_AXI_rresp !== 2'b10) begin n_bad++; $display("FAIL pt_rresp: got %b want 10", S_AXI_rresp); end
        n_cmp++; if (S_AXI_bresp !== 2'b11) begin n_bad++; $display("FAIL pt_bresp: got %b want 11", S_AXI_bresp); end
        n_cmp++; if (M_AXI_rready !== 1'b1) begin n_bad++; $display("FAIL pt_rready: got %b want 1", M_AXI_rready); end
        n_cmp++; if (M_AXI_arvalid !== 1'b0) begin n_bad++; $display("FAIL pt_arvalid: got %b want 0", M_AXI_arvalid); end
        clear_inputs();
        tick();
    endtask

    task automatic test_rd_cap();
        S_AXI_arvalid = 1; M_AXI_arready = 1; S_AXI_rready = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (S_AXI_arready !== 1'b1) begin n_bad++; $display("FAIL rd_cap_accept%0d: got %b want 1", i, S_AXI_arready); end
            tick();
        end
        n_cmp++; if (rd_outstanding !== 8'd3) begin n_bad++; $display("FAIL rd_cap_count: got %0d want 3", rd_outstanding); end
        n_cmp++; if (S_AXI_arready !== 1'b0) begin n_bad++; $display("FAIL rd_cap_arready: got %b want 0", S_AXI_arready); end
        n_cmp++; if (M_AXI_arvalid !== 1'b0) begin n_bad++; $display("FAIL rd_cap_arvalid: got %b want 0", M_AXI_arvalid); end
        tick();
        M_AXI_rvalid = 1; M_AXI_rlast = 1;
        #1;
        n_cmp++; if (S_AXI_arready !== 1'b0) begin n_bad++; $display("FAIL rd_cap_no_comb_unblock: got %b want 0", S_AXI_arready); end
        tick();
        M_AXI_rvalid = 0; M_AXI_rlast = 0;
        #1;
        n_cmp++; if (rd_outstanding !== 8'd2) begin n_bad++; $display("FAIL rd_cap_after_rlast: got %0d want 2", rd_outstanding); end
        n_cmp++; if (S_AXI_arready !== 1'b1) begin n_bad++; $display("FAIL rd_cap_unblocked: got %b want 1", S_AXI_arready); end
        tick();
        S_AXI_arvalid = 0;
        n_cmp++; if (rd_outstanding !== 8'd3) begin n_bad++; $display("FAIL rd_cap_refill: got %0d want 3", rd_outstanding); end
        M_AXI_rvalid = 1; M_AXI_rlast = 1;
        repeat (3) tick();
        M_AXI_rvalid = 0; M_AXI_rlast = 0;
        n_cmp++; if (rd_outstanding !== 8'd0) begin n_bad++; $display("FAIL rd_cap_drain: got %0d want 0", rd_outstanding); end
        n_cmp++; if (protocol_err !== 1'b0) begin n_bad++; $display("FAIL rd_cap_perr: got %b want 0", protocol_err); end
        clear_inputs();
    endtask

    task automatic test_rd_simultaneous();
        S_AXI_arvalid = 1; M_AXI_arready = 1; S_AXI_rready = 1;
        tick();
        n_cmp++; if (rd_outstanding !== 8'd1) begin n_bad++; $display("FAIL sim_pre: got %0d want 1", rd_outstanding); end
        M_AXI_rvalid = 1; M_AXI_rlast = 1;
        tick();
        S_AXI_arvalid = 0;
        n_cmp++; if (rd_outstanding !== 8'd1) begin n_bad++; $display("FAIL sim_count: got %0d want 1", rd_outstanding); end
        n_cmp++; if (protocol_err !== 1'b0) begin n_bad++; $display("FAIL sim_perr: got %b want 0", protocol_err); end
        tick();
        M_AXI_rvalid = 0; M_AXI_rlast = 0;
        n_cmp++; if (rd_outstanding !== 8'd0) begin n_bad++; $display("FAIL sim_drain: got %0d want 0", rd_outstanding); end
        clear_inputs();
    endtask

    task automatic test_w_credit();
        logic [127:0] w_pat;
        S_AXI_wvalid = 1; M_AXI_wready = 1; S_AXI_wdata = 128'hAA;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if ({M_AXI_wvalid, S_AXI_wready} !== 2'b00) begin n_bad++; $display("FAIL wc_early%0d: got %b want 00", i, {M_AXI_wvalid, S_AXI_wready}); end
            tick();
        end
        S_AXI_awvalid = 1; M_AXI_awready = 1; S_AXI_awlen = 8'd3;
        #1;
        n_cmp++; if (M_AXI_wvalid !== 1'b0) begin n_bad++; $display("FAIL wc_same_cycle: got %b want 0", M_AXI_wvalid); end
        tick();
        S_AXI_awvalid = 0;
        for (int i = 0; i < 4; i++) begin
            w_pat = 128'h1000 + 128'(i);
            S_AXI_wdata = w_pat; S_AXI_wlast = (i == 3);
            #1;
            n_cmp++; if (M_AXI_wvalid !== 1'b1) begin n_bad++; $display("FAIL wc_beat%0d_valid: got %b want 1", i, M_AXI_wvalid); end
            n_cmp++; if (M_AXI_wdata !== w_pat) begin n_bad++; $display("FAIL wc_beat%0d_data: got %h want %h", i, M_AXI_wdata, w_pat); end
            tick();
        end
        S_AXI_wlast = 0;
        #1;
        n_cmp++; if (M_AXI_wvalid !== 1'b0) begin n_bad++; $display("FAIL wc_closed: got %b want 0", M_AXI_wvalid); end
        n_cmp++; if (wr_outstanding !== 8'd1) begin n_bad++; $display("FAIL wc_wr_cnt: got %0d want 1", wr_outstanding); end
        S_AXI_wvalid = 0;
        M_AXI_bvalid = 1; S_AXI_bready = 1;
        tick();
        M_AXI_bvalid = 0;
        n_cmp++; if (wr_outstanding !== 8'd0) begin n_bad++; $display("FAIL wc_b_done: got %0d want 0", wr_outstanding); end
        clear_inputs();
    endtask

    task automatic test_wr_cap();
        S_AXI_awvalid = 1; M_AXI_awready = 1; M_AXI_wready = 1; S_AXI_bready = 1;
        tick();
        n_cmp++; if (wr_outstanding !== 8'd1) begin n_bad++; $display("FAIL wcap_first: got %0d want 1", wr_outstanding); end
        S_AXI_wvalid = 1; S_AXI_wlast = 1;
        #1;
        n_cmp++; if (M_AXI_wvalid !== 1'b1) begin n_bad++; $display("FAIL wcap_wbeat: got %b want 1", M_AXI_wvalid); end
        n_cmp++; if (S_AXI_awready !== 1'b0) begin n_bad++; $display("FAIL wcap_blocked: got %b want 0", S_AXI_awready); end
        tick();
        S_AXI_wvalid = 0; S_AXI_wlast = 0;
        tick();
        n_cmp++; if ({M_AXI_awvalid, S_AXI_awready} !== 2'b00) begin n_bad++; $display("FAIL wcap_still_blocked: got %b want 00", {M_AXI_awvalid, S_AXI_awready}); end
        M_AXI_bvalid = 1;
        #1;
        n_cmp++; if (S_AXI_awready !== 1'b0) begin n_bad++; $display("FAIL wcap_no_comb_unblock: got %b want 0", S_AXI_awready); end
        tick();
        M_AXI_bvalid = 0;
        n_cmp++; if (wr_outstanding !== 8'd0) begin n_bad++; $display("FAIL wcap_zero: got %0d want 0", wr_outstanding); end
        n_cmp++; if (S_AXI_awready !== 1'b1) begin n_bad++; $display("FAIL wcap_unblocked: got %b want 1", S_AXI_awready); end
        tick();
        S_AXI_awvalid = 0;
        n_cmp++; if (wr_outstanding !== 8'd1) begin n_bad++; $display("FAIL wcap_second: got %0d want 1", wr_outstanding); end
        S_AXI_wvalid = 1; S_AXI_wlast = 1;
        tick();
        S_AXI_wvalid = 0; S_AXI_wlast = 0; M_AXI_bvalid = 1;
        tick();
        M_AXI_bvalid = 0;
        n_cmp++; if (wr_outstanding !== 8'd0) begin n_bad++; $display("FAIL wcap_drain: got %0d want 0", wr_outstanding); end
        n_cmp++; if (protocol_err !== 1'b0) begin n_bad++; $display("FAIL wcap_perr: got %b want 0", protocol_err); end
        clear_inputs();
    endtask

    task automatic test_stray_b();
        RST_N = 1'b0;
        #3;
        RST_N = 1'b1;
        tick();
        M_AXI_bvalid = 1; S_AXI_bready = 1; M_AXI_bid = 6'h05;
        #1;
        n_cmp++; if (S_AXI_bvalid !== 1'b1) begin n_bad++; $display("FAIL stray_bvalid: got %b want 1", S_AXI_bvalid); end
        n_cmp++; if (S_AXI_bid !== 6'h05) begin n_bad++; $display("FAIL stray_bid: got %h want 05", S_AXI_bid); end
        n_cmp++; if (M_AXI_bready !== 1'b1) begin n_bad++; $display("FAIL stray_bready: got %b want 1", M_AXI_bready); end
        tick();
        M_AXI_bvalid = 0;
        n_cmp++; if (wr_outstanding !== 8'd0) begin n_bad++; $display("FAIL stray_wr: got %0d want 0", wr_outstanding); end
        n_cmp++; if (protocol_err !== 1'b1) begin n_bad++; $display("FAIL stray_perr: got %b want 1", protocol_err); end
        repeat (3) tick();
        n_cmp++; if (protocol_err !== 1'b1) begin n_bad++; $display("FAIL stray_perr_sticky: got %b want 1", protocol_err); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_burst();
        S_AXI_arvalid = 1; M_AXI_arready = 1; S_AXI_rready = 1;
        repeat (3) tick();
        S_AXI_arvalid = 0;
        M_AXI_rvalid = 1; M_AXI_rlast = 0;
        tick();
        n_cmp++; if (rd_outstanding !== 8'd3) begin n_bad++; $display("FAIL rmb_pre: got %0d want 3", rd_outstanding); end
        M_AXI_rvalid = 0;
        S_AXI_arvalid = 1;
        #2;
        RST_N = 1'b0;
        #1;
        n_cmp++; if (rd_outstanding !== 8'd0) begin n_bad++; $display("FAIL rmb_async_clear: got %0d want 0", rd_outstanding); end
        n_cmp++; if (protocol_err !== 1'b0) begin n_bad++; $display("FAIL rmb_perr_clear: got %b want 0", protocol_err); end
        tick();
        #2;
        RST_N = 1'b1;
        #1;
        n_cmp++; if ({M_AXI_arvalid, S_AXI_arready} !== 2'b11) begin n_bad++; $display("FAIL rmb_unblocked: got %b want 11", {M_AXI_arvalid, S_AXI_arready}); end
        tick();
        S_AXI_arvalid = 0;
        n_cmp++; if (rd_outstanding !== 8'd1) begin n_bad++; $display("FAIL rmb_first_ar: got %0d want 1", rd_outstanding); end
        M_AXI_rvalid = 1; M_AXI_rlast = 1;
        tick();
        n_cmp++; if (rd_outstanding !== 8'd0) begin n_bad++; $display("FAIL rmb_drain: got %0d want 0", rd_outstanding); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_rd_cap();
        test_rd_simultaneous();
        test_w_credit();
        test_wr_cap();
        test_stray_b();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
